stopwatch_counter: RTL and testbench
====================================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter FIELD_W, 6, width of each of the minutes and seconds fields.
REQ-002 Parameter MIN_MAX, 59, largest minutes value; SHALL be at most 2^FIELD_W-1.
REQ-003 Parameter SEC_MAX, 59, largest seconds value; SHALL be at most 2^FIELD_W-1.
REQ-004 Parameter PRESET_MIN, 0, minutes value loaded on reset.
REQ-005 Parameter PRESET_SEC, 0, seconds value loaded on reset.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 tick_1hz  input  1  one-cycle count-enable pulse at 1 Hz.
REQ-009 tick_adj  input  1  one-cycle adjust-enable pulse at 2 Hz.
REQ-010 pause  input  1  one-cycle pulse (debounced upstream); toggles run/pause.
REQ-011 adj  input  1  level; 1 = adjust mode.
REQ-012 sel  input  1  level; adjust target: 0 = minutes, 1 = seconds.
REQ-013 dir  input  1  level; 0 = count up, 1 = count down; sampled on each tick_1hz.
REQ-014 minutes  output  FIELD_W  current minutes, registered.
REQ-015 seconds  output  FIELD_W  current seconds, registered.
REQ-016 paused  output  1  high in PAUSED state.
REQ-017 done  output  1  high in EXPIRED state.

Function
REQ-018 States SHALL be RUN, PAUSED, ADJUST and EXPIRED; outputs SHALL be registered with no combinational input-to-output path.
REQ-019 Priority on any edge SHALL be rst > adj > pause > tick_1hz.
REQ-020 Any state with adj=1 SHALL enter ADJUST on the next edge; adj=0 in ADJUST SHALL return to RUN, including when entered from PAUSED or EXPIRED.
REQ-021 In RUN, dir=0, tick_1hz: seconds+1; at SEC_MAX, seconds->0 and minutes+1; at MIN_MAX:SEC_MAX both fields->0 and done stays 0.
REQ-022 In RUN, dir=1, tick_1hz: seconds-1; at 0, seconds->SEC_MAX and minutes-1.
REQ-023 A down-count edge that produces 00:00 SHALL enter EXPIRED on that edge; tick_1hz in RUN at 00:00 with dir=1 SHALL enter EXPIRED with values unchanged.
REQ-024 EXPIRED SHALL hold values and ignore tick_1hz and pause; only adj or rst leave it.
REQ-025 pause in RUN -> PAUSED; pause in PAUSED -> RUN; a tick_1hz in the same cycle as pause SHALL be dropped.
REQ-026 PAUSED SHALL hold both fields and ignore tick_1hz.
REQ-027 In ADJUST, each tick_adj SHALL increment only the field selected by sel, wrapping MAX->0 with no carry into the other field; tick_1hz and pause SHALL be ignored.
REQ-028 Changing sel or dir mid-operation SHALL take effect on the next relevant tick with no glitch in the fields.
REQ-029 Field arithmetic SHALL stay within FIELD_W bits; values above MAX SHALL never occur.

Reset
REQ-030 rst=1 at an edge SHALL load minutes=PRESET_MIN, seconds=PRESET_SEC, state RUN, paused=0, done=0, in any state and overriding all other inputs in that cycle.
REQ-031 Counting SHALL resume on the first tick_1hz after rst deasserts.

Structure
REQ-032 Package stopwatch_pkg SHALL hold the state encoding and the default FIELD_W/MIN_MAX/SEC_MAX constants.
REQ-033 A sub-module mod_counter (parametrised width and max; inc, dec and clear inputs; wrap/borrow output) SHALL implement each field and be instantiated twice.
REQ-034 The state machine and the priority logic SHALL live in stopwatch_counter.

Verification
REQ-035 Preset 00:58, dir=0, 3 x tick_1hz -> 00:59, 01:00, 01:01.
REQ-036 At 59:59, dir=0, tick_1hz -> 00:00 with done=0; at 00:02, dir=1, 2 ticks -> 00:01, then 00:00 with done=1 on the same edge; 3 further ticks -> hold at 00:00.
REQ-037 At 00:58, adj=1, sel=1, 3 x tick_adj -> 00:59, 00:00, 00:01 with minutes unchanged; tick_1hz during ADJUST -> no change.
REQ-038 At 03:10, pause and tick_1hz in the same cycle -> paused=1 and value 03:10; 5 ticks -> 03:10; pause -> paused=0; next tick -> 03:11.
REQ-039 rst during ADJUST with adj still high -> next edge PRESET value, state RUN, done=0; ADJUST re-entered on the following edge.
REQ-040 In EXPIRED, adj=1 then adj=0 -> state RUN, done=0, and counting resumes.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default field geometry for the stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_ADJUST  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int FIELD_W_DEF = 6;
    localparam int MIN_MAX_DEF = 59;
    localparam int SEC_MAX_DEF = 59;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up/down field counter with preset clear and a combined
// wrap/borrow flag that asserts on the edge where the field rolls over.
module mod_counter #(
    parameter int W      = 6,
    parameter int MAX    = 59,
    parameter int PRESET = 0
) (
    input  logic         clk,
    input  logic         i_clear,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_value,
    output logic         o_carry
);

    localparam logic [W-1:0] MAX_V    = W'(MAX);
    localparam logic [W-1:0] PRESET_V = W'(PRESET);

    logic [W-1:0] r_value;

    // clear beats inc, inc beats dec
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_value <= PRESET_V;
        end else if (i_inc) begin
            r_value <= (r_value == MAX_V) ? '0 : r_value + 1'b1;
        end else if (i_dec) begin
            r_value <= (r_value == '0) ? MAX_V : r_value - 1'b1;
        end
    end

    assign o_value = r_value;
    assign o_carry = !i_clear && ((i_inc && (r_value == MAX_V)) ||
                                  (!i_inc && i_dec && (r_value == '0)));

endmodule

// File: rtl/stopwatch_counter.sv
// Minutes:seconds stopwatch/timer with run, pause, adjust and expired states.
// Priority per edge: rst > adj > pause > tick_1hz.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int FIELD_W    = FIELD_W_DEF,
    parameter int MIN_MAX    = MIN_MAX_DEF,
    parameter int SEC_MAX    = SEC_MAX_DEF,
    parameter int PRESET_MIN = 0,
    parameter int PRESET_SEC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_adj,
    input  logic               pause,
    input  logic               adj,
    input  logic               sel,
    input  logic               dir,
    output logic [FIELD_W-1:0] minutes,
    output logic [FIELD_W-1:0] seconds,
    output logic               paused,
    output logic               done
);

    localparam logic [FIELD_W-1:0] ONE_V = FIELD_W'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_paused;
    logic                 r_done;
    logic                 w_sec_inc;
    logic                 w_sec_dec;
    logic                 w_min_adj;
    logic                 w_count_up;
    logic                 w_min_inc;
    logic                 w_min_dec;
    logic                 w_sec_carry;
    logic                 w_min_carry_unused;
    logic [FIELD_W-1:0]   w_min_value;
    logic [FIELD_W-1:0]   w_sec_value;
    logic                 w_at_zero;
    logic                 w_at_one;

    assign w_at_zero = (w_min_value == '0) && (w_sec_value == '0);
    assign w_at_one  = (w_min_value == '0) && (w_sec_value == ONE_V);

    always_comb begin
        w_state_next = r_state;
        w_sec_inc    = 1'b0;
        w_sec_dec    = 1'b0;
        w_min_adj    = 1'b0;
        w_count_up   = 1'b0;
        if (adj) begin
            w_state_next = ST_ADJUST;
            // the entry edge itself never adjusts; only ticks seen while in ADJUST do
            if ((r_state == ST_ADJUST) && tick_adj) begin
                if (sel) begin
                    w_sec_inc = 1'b1;
                end else begin
                    w_min_adj = 1'b1;
                end
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (pause) begin
                        w_state_next = ST_PAUSED;
                    end else if (tick_1hz) begin
                        if (!dir) begin
                            w_sec_inc  = 1'b1;
                            w_count_up = 1'b1;
                        end else if (w_at_zero) begin
                            w_state_next = ST_EXPIRED;
                        end else begin
                            w_sec_dec = 1'b1;
                            if (w_at_one) begin
                                w_state_next = ST_EXPIRED;
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (pause) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_ADJUST: w_state_next = ST_RUN;
                default:   w_state_next = r_state;
            endcase
        end
    end

    // seconds carry feeds minutes only while counting, never while adjusting
    assign w_min_inc = w_min_adj | (w_count_up & w_sec_carry);
    assign w_min_dec = w_sec_dec & w_sec_carry;

    mod_counter #(
        .W      (FIELD_W),
        .MAX    (SEC_MAX),
        .PRESET (PRESET_SEC)
    ) u_sec (
        .clk     (clk),
        .i_clear (rst),
        .i_inc   (w_sec_inc),
        .i_dec   (w_sec_dec),
        .o_value (w_sec_value),
        .o_carry (w_sec_carry)
    );

    mod_counter #(
        .W      (FIELD_W),
        .MAX    (MIN_MAX),
        .PRESET (PRESET_MIN)
    ) u_min (
        .clk     (clk),
        .i_clear (rst),
        .i_inc   (w_min_inc),
        .i_dec   (w_min_dec),
        .o_value (w_min_value),
        .o_carry (w_min_carry_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_paused <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_paused <= (w_state_next == ST_PAUSED);
            r_done   <= (w_state_next == ST_EXPIRED);
        end
    end

    assign minutes = w_min_value;
    assign seconds = w_sec_value;
    assign paused  = r_paused;
    assign done    = r_done;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed and random stimulus for stopwatch_counter against a total-seconds
// reference model; preset is 00:58 so the reset value is distinguishable.
module tb_stopwatch_counter;

    localparam int NMIN  = 60;
    localparam int NSEC  = 60;
    localparam int P_MIN = 0;
    localparam int P_SEC = 58;

    localparam int MODE_RUN = 0;
    localparam int MODE_PAU = 1;
    localparam int MODE_ADJ = 2;
    localparam int MODE_EXP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_adj = 1'b0;
    logic       pause = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       dir = 1'b0;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       paused;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int m_min = 0;
    int m_sec = 0;
    int m_mode = MODE_RUN;

    always #5 clk = ~clk;

    stopwatch_counter #(
        .FIELD_W    (6),
        .MIN_MAX    (NMIN - 1),
        .SEC_MAX    (NSEC - 1),
        .PRESET_MIN (P_MIN),
        .PRESET_SEC (P_SEC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .tick_adj (tick_adj),
        .pause    (pause),
        .adj      (adj),
        .sel      (sel),
        .dir      (dir),
        .minutes  (minutes),
        .seconds  (seconds),
        .paused   (paused),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour: the time is a single count of seconds modulo one hour.
    task automatic model_edge(input logic r, a, p, t1, ta, s, d);
        int total;
        if (r) begin
            m_min = P_MIN; m_sec = P_SEC; m_mode = MODE_RUN;
        end else if (a) begin
            if (m_mode == MODE_ADJ && ta) begin
                if (s) m_sec = (m_sec + 1) % NSEC;
                else   m_min = (m_min + 1) % NMIN;
            end
            m_mode = MODE_ADJ;
        end else if (m_mode == MODE_ADJ) begin
            m_mode = MODE_RUN;
        end else if (m_mode == MODE_PAU) begin
            if (p) m_mode = MODE_RUN;
        end else if (m_mode == MODE_RUN) begin
            if (p) begin
                m_mode = MODE_PAU;
            end else if (t1) begin
                total = m_min * NSEC + m_sec;
                if (!d) begin
                    total = (total + 1) % (NMIN * NSEC);
                end else if (total == 0) begin
                    m_mode = MODE_EXP;
                end else begin
                    total = total - 1;
                    if (total == 0) m_mode = MODE_EXP;
                end
                m_min = total / NSEC;
                m_sec = total % NSEC;
            end
        end
    endtask

    task automatic step(input logic r, a, p, t1, ta, s, d, input string tag);
        @(negedge clk);
        rst = r; adj = a; pause = p; tick_1hz = t1; tick_adj = ta; sel = s; dir = d;
        @(posedge clk);
        model_edge(r, a, p, t1, ta, s, d);
        #1;
        check({tag, ".min"},    32'(minutes), 32'(m_min));
        check({tag, ".sec"},    32'(seconds), 32'(m_sec));
        check({tag, ".paused"}, 32'(paused),  32'(m_mode == MODE_PAU));
        check({tag, ".done"},   32'(done),    32'(m_mode == MODE_EXP));
        $display("step %-10s rst=%0b adj=%0b pause=%0b t1=%0b ta=%0b sel=%0b dir=%0b -> %02d:%02d paused=%0b done=%0b",
                 tag, r, a, p, t1, ta, s, d, minutes, seconds, paused, done);
    endtask

    task automatic expect_lit(input string tag, input int mm, input int ss, input int p, input int dn);
        check({tag, ".lit_min"},    32'(minutes), 32'(mm));
        check({tag, ".lit_sec"},    32'(seconds), 32'(ss));
        check({tag, ".lit_paused"}, 32'(paused),  32'(p));
        check({tag, ".lit_done"},   32'(done),    32'(dn));
    endtask

    // Enters ADJUST and walks both fields to mm:ss; leaves the DUT in ADJUST.
    task automatic set_time(input int mm, input int ss);
        int n_m;
        int n_s;
        step(0, 1, 0, 0, 0, 0, 0, "adj_enter");
        n_m = (mm - m_min + NMIN) % NMIN;
        n_s = (ss - m_sec + NSEC) % NSEC;
        repeat (n_m) step(0, 1, 0, 0, 1, 0, 0, "adj_min");
        repeat (n_s) step(0, 1, 0, 0, 1, 1, 0, "adj_sec");
    endtask

    initial begin : stim
        logic r_adj;
        logic r_sel;
        logic r_dir;

        step(1, 0, 0, 0, 0, 0, 0, "reset");
        expect_lit("reset", 0, 58, 0, 0);

        // up-count across a minute boundary
        step(0, 0, 0, 1, 0, 0, 0, "up1"); expect_lit("up1", 0, 59, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, "up2"); expect_lit("up2", 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, "up3"); expect_lit("up3", 1, 1, 0, 0);

        // full rollover, then down-count to expiry and hold
        set_time(59, 59);
        step(0, 0, 0, 0, 0, 0, 0, "adj_exit");
        step(0, 0, 0, 1, 0, 0, 0, "roll"); expect_lit("roll", 0, 0, 0, 0);
        set_time(0, 2);
        step(0, 0, 0, 0, 0, 0, 1, "adj_exit");
        step(0, 0, 0, 1, 0, 0, 1, "dn1"); expect_lit("dn1", 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 1, "dn2"); expect_lit("dn2", 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 1, 0, 0, 1, "exp_hold");
        expect_lit("exp_hold", 0, 0, 0, 1);
        step(0, 0, 1, 1, 0, 0, 0, "exp_pause"); expect_lit("exp_pause", 0, 0, 0, 1);

        // leave EXPIRED through ADJUST and resume counting
        step(0, 1, 0, 0, 0, 0, 0, "exp_adj"); expect_lit("exp_adj", 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, "exp_run");
        step(0, 0, 0, 1, 0, 0, 0, "resume"); expect_lit("resume", 0, 1, 0, 0);

        // seconds adjust wraps without carrying; tick_1hz and pause ignored
        set_time(0, 58);
        step(0, 1, 0, 0, 1, 1, 0, "adj_w1"); expect_lit("adj_w1", 0, 59, 0, 0);
        step(0, 1, 0, 0, 1, 1, 0, "adj_w2"); expect_lit("adj_w2", 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 1, 0, "adj_w3"); expect_lit("adj_w3", 0, 1, 0, 0);
        step(0, 1, 1, 1, 0, 1, 0, "adj_t1"); expect_lit("adj_t1", 0, 1, 0, 0);

        // pause drops a simultaneous tick
        set_time(3, 10);
        step(0, 0, 0, 0, 0, 0, 0, "adj_exit");
        step(0, 0, 1, 1, 0, 0, 0, "pau_on"); expect_lit("pau_on", 3, 10, 1, 0);
        repeat (5) step(0, 0, 0, 1, 0, 0, 0, "pau_hold");
        expect_lit("pau_hold", 3, 10, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0, "pau_off"); expect_lit("pau_off", 3, 10, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, "pau_tick"); expect_lit("pau_tick", 3, 11, 0, 0);

        // reset overrides adj, then ADJUST is re-entered
        step(0, 1, 0, 0, 0, 0, 0, "rst_adj0");
        step(1, 1, 0, 1, 1, 1, 0, "rst_adj"); expect_lit("rst_adj", 0, 58, 0, 0);
        step(0, 1, 0, 0, 1, 1, 0, "reenter"); expect_lit("reenter", 0, 58, 0, 0);
        step(0, 1, 0, 1, 1, 1, 0, "reenter2"); expect_lit("reenter2", 0, 59, 0, 0);

        // random mix, starting close to zero so expiry is reachable
        set_time(0, 4);
        r_adj = 1'b0; r_sel = 1'b0; r_dir = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) r_adj = ~r_adj;
            if ($urandom_range(0, 7) == 0)  r_sel = ~r_sel;
            if ($urandom_range(0, 15) == 0) r_dir = ~r_dir;
            step(($urandom_range(0, 149) == 0), r_adj, ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), r_sel, r_dir, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
